starfield_speed_ramp: RTL and testbench

Upstream control stage for the starfield generator. The block holds CPU-programmed target-speed and ramp-rate registers. Once per frame, at the rising edge of vblank, it steps a current-speed value toward the target. Each change is forwarded to the starfield's speed register as a one-cycle write strobe, which gives smooth acceleration and deceleration instead of abrupt jumps.

---
 rtl/starfield_pkg.sv | 43 ++++
 rtl/starfield_speed_ramp_vblank_edge.sv | 22 ++
 rtl/starfield_speed_ramp.sv | 169 ++++++++++++++++
 tb/tb_starfield_speed_ramp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/starfield_pkg.sv
// Shared definitions for the starfield speed ramp: register map, control bits,
// FSM state encoding and the clamped step helper.
package starfield_pkg;

    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_RATE   = 2'd1;
    localparam logic [1:0] REG_STEP   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int CTRL_SNAP_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_STEP  = 2'd2,
        ST_EMIT  = 2'd3
    } ramp_state_e;

    // Move cur toward tgt by stp; the comparison happens before the add or
    // subtract so an 8-bit value can never wrap past the target.
    function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] stp);
        logic [7:0] res;
        if (cur < tgt) begin
            if ((tgt - cur) <= stp) begin
                res = tgt;
            end else begin
                res = cur + stp;
            end
        end else if (cur > tgt) begin
            if ((cur - tgt) <= stp) begin
                res = tgt;
            end else begin
                res = cur - stp;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/starfield_speed_ramp_vblank_edge.sv
// Registers the vblank level and flags its rising edge for one cycle.
module vblank_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vblank,
    output logic vb_rise
);

    logic vblank_q_r;

    // Delayed copy of vblank for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q_r <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
        end
    end

    assign vb_rise = vblank & ~vblank_q_r;

endmodule

// File: rtl/starfield_speed_ramp.sv
// Per-frame speed ramp toward a CPU-programmed target, emitting one-cycle
// write strobes to the starfield. Define STARFIELD_SPEED_EASE_EN for ease-out stepping.
module starfield_speed_ramp
    import starfield_pkg::*;
#(
    parameter logic [7:0] INIT_SPEED = 8'd0,
    parameter logic [7:0] INIT_RATE  = 8'd1,
    parameter logic [7:0] INIT_STEP  = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wr,
    output logic [7:0] cpu_data_out,
    input  logic       vblank,
    output logic [7:0] sf_data_out,
    output logic       sf_write,
    output logic       busy
);

    ramp_state_e state_r, state_n;
    logic [7:0]  target_r, target_n;
    logic [7:0]  rate_r, rate_n;
    logic [7:0]  step_r, step_n;
    logic [7:0]  current_r, current_n;
    logic [7:0]  frame_cnt_r, frame_cnt_n;
    logic [7:0]  sf_data_r, sf_data_n;
    logic        sf_write_r, sf_write_n;
    logic        vb_rise_s;
    logic        snap_s;
    logic [7:0]  rate_eff_s;
    logic [7:0]  step_eff_s;

    vblank_edge u_vblank_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .vblank  (vblank),
        .vb_rise (vb_rise_s)
    );

    assign rate_eff_s = (rate_r == 8'd0) ? 8'd1 : rate_r;

`ifdef STARFIELD_SPEED_EASE_EN
    logic [7:0] dist_s;
    assign dist_s     = (current_r > target_r) ? (current_r - target_r) : (target_r - current_r);
    assign step_eff_s = ((dist_s >> 2) == 8'd0) ? 8'd1 : (dist_s >> 2);
`else
    assign step_eff_s = (step_r == 8'd0) ? 8'd1 : step_r;
`endif

    assign snap_s = cpu_wr && (cpu_addr == REG_CTRL) && cpu_data_in[CTRL_SNAP_BIT];

    // Next-state logic for the register file, the ramp FSM and the strobe outputs.
    always_comb begin
        state_n     = state_r;
        target_n    = target_r;
        rate_n      = rate_r;
        step_n      = step_r;
        current_n   = current_r;
        frame_cnt_n = frame_cnt_r;
        sf_data_n   = sf_data_r;
        sf_write_n  = 1'b0;

        if (cpu_wr) begin
            case (cpu_addr)
                REG_TARGET: target_n = cpu_data_in;
                REG_RATE:   rate_n   = cpu_data_in;
                REG_STEP:   step_n   = cpu_data_in;
                default:    target_n = target_r;
            endcase
        end else begin
            target_n = target_r;
        end

        case (state_r)
            ST_IDLE: begin
                frame_cnt_n = 8'd0;
                if (current_r != target_r) begin
                    state_n = ST_COUNT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (current_r == target_r) begin
                    frame_cnt_n = 8'd0;
                    state_n     = ST_IDLE;
                end else if (vb_rise_s) begin
                    if (({1'b0, frame_cnt_r} + 9'd1) >= {1'b0, rate_eff_s}) begin
                        frame_cnt_n = 8'd0;
                        state_n     = ST_STEP;
                    end else begin
                        frame_cnt_n = frame_cnt_r + 8'd1;
                    end
                end else begin
                    state_n = ST_COUNT;
                end
            end
            ST_STEP: begin
                current_n  = step_toward(current_r, target_r, step_eff_s);
                sf_data_n  = current_n;
                sf_write_n = 1'b1;
                state_n    = ST_EMIT;
            end
            ST_EMIT: begin
                if (current_r == target_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_COUNT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Snap pre-empts whatever the FSM was doing, including a pending STEP;
        // the following STEP is a no-op move that routes the value to EMIT.
        if (snap_s) begin
            current_n   = target_r;
            frame_cnt_n = 8'd0;
            sf_data_n   = sf_data_r;
            sf_write_n  = 1'b0;
            state_n     = ST_STEP;
        end else begin
            frame_cnt_n = frame_cnt_n;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            target_r    <= INIT_SPEED;
            rate_r      <= INIT_RATE;
            step_r      <= INIT_STEP;
            current_r   <= INIT_SPEED;
            frame_cnt_r <= 8'd0;
            sf_data_r   <= INIT_SPEED;
            sf_write_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            target_r    <= target_n;
            rate_r      <= rate_n;
            step_r      <= step_n;
            current_r   <= current_n;
            frame_cnt_r <= frame_cnt_n;
            sf_data_r   <= sf_data_n;
            sf_write_r  <= sf_write_n;
        end
    end

    // CPU read-back mux.
    always_comb begin
        case (cpu_addr)
            REG_TARGET: cpu_data_out = target_r;
            REG_RATE:   cpu_data_out = rate_r;
            REG_STEP:   cpu_data_out = step_r;
            REG_CTRL:   cpu_data_out = current_r;
            default:    cpu_data_out = 8'd0;
        endcase
    end

    assign sf_data_out = sf_data_r;
    assign sf_write    = sf_write_r;
    assign busy        = (current_r != target_r);

endmodule

// File: tb/tb_starfield_speed_ramp.sv
// Scoreboard bench for starfield_speed_ramp: a frame-level speed model predicts
// strobe values and cycles; a monitor pops and compares on every sf_write.
module tb_starfield_speed_ramp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_data_in = 8'd0;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_data_out;
    logic       vblank = 1'b0;
    logic [7:0] sf_data_out;
    logic       sf_write;
    logic       busy;

    starfield_speed_ramp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_wr       (cpu_wr),
        .cpu_data_out (cpu_data_out),
        .vblank       (vblank),
        .sf_data_out  (sf_data_out),
        .sf_write     (sf_write),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int q_val[$];
    int q_cyc[$];

    // Frame-level model: speeds, frames counted since the last step, last emitted value.
    int m_cur, m_tgt, m_rate, m_step, m_fcnt, m_last;

    function automatic int eff_step(int cur, int tgt, int stp);
        int s;
`ifdef STARFIELD_SPEED_EASE_EN
        s = ((cur > tgt) ? (cur - tgt) : (tgt - cur)) / 4;
        if (s < 1) s = 1;
`else
        s = (stp == 0) ? 1 : stp;
`endif
        return s;
    endfunction

    function automatic int move(int cur, int tgt, int s);
        if (cur < tgt) return (tgt - cur <= s) ? tgt : cur + s;
        if (cur > tgt) return (cur - tgt <= s) ? tgt : cur - s;
        return cur;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_rate = 1; m_step = 1; m_fcnt = 0; m_last = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic read_chk(input logic [1:0] addr, input int exp, input string name);
        cpu_addr = addr;
        #1;
        check(name, int'(cpu_data_out), exp);
    endtask

    // Monitor: every strobe must match the oldest predicted one, value and cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sf_write === 1'b1) begin
            checks++;
            if (q_val.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got value %0d at cycle %0d, expected no strobe", sf_data_out, cyc);
            end else begin
                int ev, ec;
                ev = q_val.pop_front();
                ec = q_cyc.pop_front();
                if (int'(sf_data_out) != ev || cyc != ec) begin
                    errors++;
                    $display("FAIL strobe: got value %0d at cycle %0d, expected value %0d at cycle %0d",
                             sf_data_out, cyc, ev, ec);
                end
            end
        end
    end

    task automatic settle_chk();
        if (m_cur == m_tgt) m_fcnt = 0;
        check("busy", int'(busy), (m_cur != m_tgt) ? 1 : 0);
        check("sf_data_hold", int'(sf_data_out), m_last);
        read_chk(2'd3, m_cur, "current_read");
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
        int c;
        cpu_addr = addr; cpu_data_in = data; cpu_wr = 1'b1;
        c = cyc;
        case (addr)
            2'd0: m_tgt = data;
            2'd1: m_rate = data;
            2'd2: m_step = data;
            default: begin
                if (data[0]) begin
                    m_cur = m_tgt; m_fcnt = 0; m_last = m_tgt;
                    q_val.push_back(m_tgt); q_cyc.push_back(c + 2);
                end
            end
        endcase
        tick(1);
        cpu_wr = 1'b0;
        tick(3);
        read_chk(addr, (addr == 2'd3) ? m_cur : int'(data), "reg_read");
        settle_chk();
    endtask

    task automatic vpulse();
        int c;
        vblank = 1'b1;
        c = cyc;
        if (m_cur != m_tgt) begin
            m_fcnt++;
            if (m_fcnt >= ((m_rate == 0) ? 1 : m_rate)) begin
                m_fcnt = 0;
                m_cur = move(m_cur, m_tgt, eff_step(m_cur, m_tgt, m_step));
                m_last = m_cur;
                q_val.push_back(m_cur); q_cyc.push_back(c + 2);
            end
        end
        tick(2);
        vblank = 1'b0;
        tick(4);
        settle_chk();
    endtask

    initial begin
        model_reset();
        tick(3);
        check("rst_sf_write", int'(sf_write), 0);
        check("rst_sf_data", int'(sf_data_out), 0);
        check("rst_busy", int'(busy), 0);
        read_chk(2'd3, 0, "rst_current");
        read_chk(2'd1, 1, "rst_rate");
        read_chk(2'd2, 1, "rst_step");
        rst_n = 1'b1;
        tick(2);

        // Linear ramp 0 -> 8 by 2.
        cpu_write(2'd1, 8'd1);
        cpu_write(2'd2, 8'd2);
        cpu_write(2'd0, 8'd8);
        repeat (4) vpulse();
        check("ramp_done_busy", int'(busy), 0);

        // Downward ramp with clamp: 10 -> 3 by 4.
        cpu_write(2'd0, 8'd10);
        cpu_write(2'd3, 8'd1);
        cpu_write(2'd0, 8'd3);
        cpu_write(2'd2, 8'd4);
        repeat (3) vpulse();

        // Rate 3: only the third frame steps.
        cpu_write(2'd0, 8'd0);
        cpu_write(2'd3, 8'd1);
        cpu_write(2'd1, 8'd3);
        cpu_write(2'd0, 8'd1);
        repeat (4) vpulse();

        // Mid-ramp target change followed by snap, then a fresh count.
        cpu_write(2'd1, 8'd1);
        cpu_write(2'd2, 8'd5);
        cpu_write(2'd0, 8'd50);
        repeat (2) vpulse();
        cpu_write(2'd0, 8'd200);
        cpu_write(2'd3, 8'd1);
        cpu_write(2'd1, 8'd2);
        cpu_write(2'd0, 8'd190);
        repeat (3) vpulse();

        // Reset while the FSM sits in STEP: no strobe, everything back to reset.
        cpu_write(2'd1, 8'd1);
        cpu_write(2'd0, 8'd100);
        vblank = 1'b1;
        tick(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_sf_write", int'(sf_write), 0);
        check("midrst_sf_data", int'(sf_data_out), 0);
        check("midrst_busy", int'(busy), 0);
        read_chk(2'd0, 0, "midrst_target");
        read_chk(2'd3, 0, "midrst_current");
        vblank = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        settle_chk();

        // Randomized mix of register writes, snaps and frames.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: vpulse();
                5: cpu_write(2'd0, 8'($urandom_range(0, 40)));
                6: cpu_write(2'd1, 8'($urandom_range(0, 3)));
                7: cpu_write(2'd2, 8'($urandom_range(0, 6)));
                default: cpu_write(2'd3, 8'($urandom_range(0, 255)));
            endcase
        end

        for (int i = 0; i < 20 && q_val.size() != 0; i++) tick(1);
        check("queue_drained", q_val.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
